// File: rtl/cpu_pkg.sv
// Shared encodings for the register-file write-port source multiplexer/arbiter.
package cpu_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first valid source at or above ptr, wrapping modulo N_SRC.
module rr_pick #(
  parameter int N_SRC = 7,
  parameter int SEL_W = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // One spare bit keeps ptr+k from overflowing before the modulo fold.
  localparam logic [SEL_W:0] NW = (SEL_W+1)'(N_SRC);

  logic [SEL_W:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= NW) cand = cand - NW;
      if (!found && valid[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_wr_arb.sv
// Register-file write-port source selector: direct index or round-robin arbitration
// into a single output register.
module mux_wr_arb
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_SRC = 7,
  localparam int SEL_W = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]       src_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_src,
  output logic                   sel_err,
  output logic                   dbg_state,
  output logic [SEL_W-1:0]       dbg_rr_ptr
);

  // Handshake: a source transfers when src_valid[i] && src_ready[i] in the same cycle;
  // the output transfers when out_valid && out_ready. src_ready never depends on itself.

  localparam logic [SEL_W:0] NW = (SEL_W+1)'(N_SRC);

  wr_state_t        state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             can_load;
  logic             sel_legal;
  logic             accept;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] next_ptr;

  rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .valid (src_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    // Reset gates the load window so no source sees a handshake while reset is low.
    can_load  = reset && ((state == ST_EMPTY) || out_ready);
    sel_legal = ({1'b0, selector} < NW);
    grant     = (mode == MODE_RR) ? pick_idx : selector;
    if (mode == MODE_RR) accept = can_load && pick_found;
    else                 accept = can_load && sel_legal && src_valid[selector];
    src_ready = accept ? ({{(N_SRC-1){1'b0}}, 1'b1} << grant) : '0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant == SEL_W'(i)) sel_data = src_data[i*WIDTH +: WIDTH];
    end
    next_ptr = (pick_idx == SEL_W'(N_SRC-1)) ? '0 : pick_idx + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= (mode == MODE_DIRECT) && !sel_legal && (|src_valid);
      if (accept) begin
        state    <= ST_FULL;
        out_data <= sel_data;
        out_src  <= grant;
        if (mode == MODE_RR) rr_ptr <= next_ptr;
      end else if (out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign out_valid  = (state == ST_FULL);
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_mux_wr_arb.sv
// Directed bench for mux_wr_arb: direct select, backpressure, round-robin, wrap,
// illegal selector, back-to-back and asynchronous reset.
module tb_mux_wr_arb;

  localparam int WIDTH = 32;
  localparam int N_SRC = 7;
  localparam int SEL_W = 3;

  logic                   clk;
  logic                   reset;
  logic                   mode;
  logic [SEL_W-1:0]       selector;
  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_src;
  logic                   sel_err;
  logic                   dbg_state;
  logic [SEL_W-1:0]       dbg_rr_ptr;

  int checks;
  int errors;

  mux_wr_arb #(.WIDTH(WIDTH), .N_SRC(N_SRC)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .selector   (selector),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .sel_err    (sel_err),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    src_valid = '0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; selector = '0; src_valid = 7'h7F;
    out_ready = 1'b1; src_data = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL reset_out_src got %0d want 0", out_src); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    checks++; if (src_ready !== 7'h00) begin errors++; $display("FAIL reset_src_ready got %h want 00", src_ready); end
    checks++; if (dbg_rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", dbg_rr_ptr); end
    src_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_direct();
    for (int i = 0; i < N_SRC; i++) set_data(i, 32'h1000_0000 + i);
    set_data(3, 32'hDEADBEEF);
    mode = 1'b0; selector = 3'd3; src_valid = 7'h08; out_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 7'h08) begin errors++; $display("FAIL direct_src_ready got %h want 08", src_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL direct_out_data got %h want deadbeef", out_data); end
    checks++; if (out_src !== 3'd3) begin errors++; $display("FAIL direct_out_src got %0d want 3", out_src); end
    // selected source idle while others are valid: nothing taken
    selector = 3'd2; src_valid = 7'h7B;
    #1;
    checks++; if (src_ready !== 7'h00) begin errors++; $display("FAIL direct_idle_src_ready got %h want 00", src_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL direct_idle_out_valid got %b want 0", out_valid); end
    checks++; if (dbg_rr_ptr !== 3'd0) begin errors++; $display("FAIL direct_rr_ptr got %0d want 0", dbg_rr_ptr); end
    drain();
  endtask

  task automatic test_backpressure();
    mode = 1'b0; selector = 3'd1; src_valid = 7'h02; out_ready = 1'b0;
    set_data(1, 32'hAAAA_0001); set_data(4, 32'hBBBB_0004);
    step();
    checks++; if (out_data !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_load got %h want aaaa0001", out_data); end
    selector = 3'd4; src_valid = 7'h7F;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (src_ready !== 7'h00) begin errors++; $display("FAIL bp_src_ready cyc %0d got %h want 00", c, src_ready); end
      step();
      checks++; if (out_data !== 32'hAAAA_0001 || out_src !== 3'd1 || out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold cyc %0d got %h/%0d/%b want aaaa0001/1/1", c, out_data, out_src, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 7'h10) begin errors++; $display("FAIL bp_release_ready got %h want 10", src_ready); end
    step();
    src_valid = '0;
    checks++; if (out_data !== 32'hBBBB_0004 || out_src !== 3'd4) begin errors++; $display("FAIL bp_transfer got %h/%0d want bbbb0004/4", out_data, out_src); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_rr();
    logic [SEL_W-1:0] exp_src [8];
    exp_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    for (int i = 0; i < N_SRC; i++) set_data(i, 32'hC000_0000 + i);
    mode = 1'b1; src_valid = 7'h7F; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_src !== exp_src[k])
        begin errors++; $display("FAIL rr_seq step %0d got src %0d valid %b want %0d", k, out_src, out_valid, exp_src[k]); end
      checks++; if (out_data !== 32'hC000_0000 + 32'(exp_src[k]))
        begin errors++; $display("FAIL rr_data step %0d got %h want %h", k, out_data, 32'hC000_0000 + 32'(exp_src[k])); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rr_sel_err step %0d got %b want 0", k, sel_err); end
    end
    checks++; if (dbg_rr_ptr !== 3'd1) begin errors++; $display("FAIL rr_ptr_after got %0d want 1", dbg_rr_ptr); end
    drain();
  endtask

  task automatic test_wrap();
    mode = 1'b1; out_ready = 1'b1; src_valid = 7'h10;
    step();
    checks++; if (out_src !== 3'd4) begin errors++; $display("FAIL wrap_setup_src got %0d want 4", out_src); end
    drain();
    checks++; if (dbg_rr_ptr !== 3'd5) begin errors++; $display("FAIL wrap_ptr5 got %0d want 5", dbg_rr_ptr); end
    src_valid = 7'h03;
    #1;
    checks++; if (src_ready !== 7'h01) begin errors++; $display("FAIL wrap_src_ready got %h want 01", src_ready); end
    step();
    checks++; if (out_src !== 3'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_grant got %0d/%b want 0/1", out_src, out_valid); end
    checks++; if (dbg_rr_ptr !== 3'd1) begin errors++; $display("FAIL wrap_ptr_next got %0d want 1", dbg_rr_ptr); end
    drain();
  endtask

  task automatic test_illegal();
    mode = 1'b0; selector = 3'd7; src_valid = 7'h7F; out_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 7'h00) begin errors++; $display("FAIL ill_src_ready got %h want 00", src_ready); end
    step();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL ill_sel_err got %b want 1", sel_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_out_valid got %b want 0", out_valid); end
    src_valid = '0;
    step();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL ill_pulse_end got %b want 0", sel_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_out_valid2 got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; selector = 3'd2; src_valid = 7'h04; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_data(2, 32'hE000_0000 + k);
      #1;
      checks++; if (src_ready !== 7'h04) begin errors++; $display("FAIL b2b_ready %0d got %h want 04", k, src_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hE000_0000 + k)
        begin errors++; $display("FAIL b2b_data %0d got %h/%b want %h/1", k, out_data, out_valid, 32'hE000_0000 + k); end
    end
    checks++; if (dbg_rr_ptr !== 3'd1) begin errors++; $display("FAIL b2b_rr_ptr got %0d want 1", dbg_rr_ptr); end
    drain();
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; src_valid = 7'h04; out_ready = 1'b0;
    set_data(2, 32'h5555_AAAA);
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd2) begin errors++; $display("FAIL rmid_setup got %b/%0d want 1/2", out_valid, out_src); end
    src_valid = 7'h7F;
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_out_data got %h want 0", out_data); end
    checks++; if (dbg_rr_ptr !== 3'd0) begin errors++; $display("FAIL rmid_rr_ptr got %0d want 0", dbg_rr_ptr); end
    checks++; if (src_ready !== 7'h00) begin errors++; $display("FAIL rmid_src_ready got %h want 00", src_ready); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (src_ready !== 7'h01) begin errors++; $display("FAIL rmid_first_ready got %h want 01", src_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd0) begin errors++; $display("FAIL rmid_first_accept got %b/%0d want 1/0", out_valid, out_src); end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_direct();
    test_backpressure();
    test_rr();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_wr_arb.md
MUX_WR_ARB -- requirements
Module: mux_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of each source and of the output.
REQ-002 SHALL have parameter N_SRC, default 7, meaning the number of sources (legal range 2..16).
REQ-003 SHALL have localparam SEL_W = clog2(N_SRC), minimum 1, meaning the source index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 1: 0 = direct select, 1 = round-robin arbitration.
REQ-007 SHALL have port selector, input, SEL_W, the source index used in direct mode.
REQ-008 SHALL have port src_valid, input, N_SRC, with one valid bit per source.
REQ-009 SHALL have port src_data, input, N_SRC*WIDTH, where source i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port src_ready, output, N_SRC, one-hot or zero, marking the source whose data is taken this cycle.
REQ-011 SHALL have port out_valid, output, 1, meaning the output register holds data.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer (register-file write port) accepts the data.
REQ-013 SHALL have port out_data, output, WIDTH, the registered selected data.
REQ-014 SHALL have port out_src, output, SEL_W, the index of the source that produced out_data.
REQ-015 SHALL have port sel_err, output, 1, a one-cycle pulse reporting an out-of-range selector.

Function
REQ-016 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL treat the block as able to load in a cycle when the state is EMPTY, or when it is FULL and out_ready=1.
REQ-018 SHALL, in direct mode with a legal selector and src_valid[selector]=1 in a load cycle, assert src_ready[selector] and register that source's data and index; latency from accept to out_valid is 1 cycle.
REQ-019 SHALL, in direct mode, take nothing when src_valid[selector]=0, even if other sources are valid.
REQ-020 SHALL, in direct mode with selector >= N_SRC, assert no src_ready and pulse sel_err for 1 cycle per such cycle in which src_valid is nonzero.
REQ-021 SHALL, in arbitration mode, grant the first valid source at or above pointer rr_ptr, wrapping modulo N_SRC; sel_err stays 0.
REQ-022 SHALL, after each arbitration grant i, set rr_ptr to (i+1) mod N_SRC; rr_ptr SHALL NOT change in direct mode or in cycles without a grant.
REQ-023 SHALL, on a FULL to EMPTY transition (out_ready=1 with no new accept), clear out_valid in the next cycle.
REQ-024 SHALL, in the FULL state with out_ready=1 and a new accept in the same cycle, replace the data back-to-back with no bubble (full throughput).
REQ-025 SHALL, while FULL and out_ready=0, hold out_data and out_src stable and keep every src_ready at 0.
REQ-026 SHALL sample mode every cycle, so a mode change affects only the next accept; held data is unaffected.
REQ-027 SHALL leave src_ready combinational from mode, selector, src_valid, rr_ptr, state and out_ready, with no path from src_ready back to src_valid.

Reset
REQ-028 SHALL, on reset low, immediately force state=EMPTY, out_valid=0, out_data=0, out_src=0, rr_ptr=0 and sel_err=0.
REQ-029 SHALL, when reset is asserted mid-transfer, discard held data with no handshake completion; src_ready SHALL be 0 while reset is low.
REQ-030 SHALL release reset synchronously to clk through the integrating design; the block's first accept is possible on the first edge with reset high.

Structure
REQ-031 SHALL declare the mode encodings (MODE_DIRECT=0, MODE_RR=1) and the FSM state encoding in shared package cpu_pkg.
REQ-032 SHALL place the round-robin priority search in one sub-module, rr_pick, which takes the valid vector and pointer and returns the grant index and a found flag, combinationally.

Verification
REQ-033 SHALL verify direct mode: WIDTH=32, N_SRC=7, selector=3, src_valid=0x08, src_data[3]=0xDEADBEEF -> next cycle out_valid=1, out_data=0xDEADBEEF, out_src=3.
REQ-034 SHALL verify backpressure: out_ready=0 for 5 cycles while FULL, with new valid sources present -> out_data stable, src_ready=0, then one transfer after out_ready=1.
REQ-035 SHALL verify round-robin: mode=1, src_valid=0x7F held, out_ready=1 -> out_src sequence 0,1,2,3,4,5,6,0 on consecutive cycles.
REQ-036 SHALL verify wrap: rr_ptr=5 with src_valid=0x03 -> grant 0 and rr_ptr becomes 1.
REQ-037 SHALL verify an illegal selector: mode=0, selector=7, src_valid=0x7F -> sel_err pulses, src_ready=0 and out_valid remains 0.
REQ-038 SHALL verify reset mid-operation: reset low while FULL -> out_valid=0 and out_data=0 without waiting for a clk edge, and rr_ptr=0.
